// File: rtl/axi_lite_master_if.sv
// Bus bundle for axi_lite_master: command/response channels plus the AXI4-Lite initiator ports.
// The master modport is the DUT view; the slave modport is the environment view.
interface axi_lite_master_if #(
    parameter int ADDR_W_p = 4
);
    logic                i_cmd_valid;
    logic                o_cmd_ready;
    logic                i_cmd_write;
    logic [ADDR_W_p-1:0] i_cmd_addr;
    logic [31:0]         i_cmd_wdata;
    logic [3:0]          i_cmd_wstrb;

    logic                o_rsp_valid;
    logic                i_rsp_ready;
    logic [31:0]         o_rsp_rdata;
    logic [1:0]          o_rsp_resp;

    logic [ADDR_W_p-1:0] o_axi_awaddr;
    logic                o_axi_awvalid;
    logic                i_axi_awready;
    logic [31:0]         o_axi_wdata;
    logic [3:0]          o_axi_wstrb;
    logic                o_axi_wvalid;
    logic                i_axi_wready;
    logic [1:0]          i_axi_bresp;
    logic                i_axi_bvalid;
    logic                o_axi_bready;
    logic [ADDR_W_p-1:0] o_axi_araddr;
    logic                o_axi_arvalid;
    logic                i_axi_arready;
    logic [31:0]         i_axi_rdata;
    logic [1:0]          i_axi_rresp;
    logic                i_axi_rvalid;
    logic                o_axi_rready;

    modport master (
        input  i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata, i_cmd_wstrb, i_rsp_ready,
        input  i_axi_awready, i_axi_wready, i_axi_bresp, i_axi_bvalid,
        input  i_axi_arready, i_axi_rdata, i_axi_rresp, i_axi_rvalid,
        output o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_resp,
        output o_axi_awaddr, o_axi_awvalid, o_axi_wdata, o_axi_wstrb, o_axi_wvalid,
        output o_axi_bready, o_axi_araddr, o_axi_arvalid, o_axi_rready
    );

    modport slave (
        output i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata, i_cmd_wstrb, i_rsp_ready,
        output i_axi_awready, i_axi_wready, i_axi_bresp, i_axi_bvalid,
        output i_axi_arready, i_axi_rdata, i_axi_rresp, i_axi_rvalid,
        input  o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_resp,
        input  o_axi_awaddr, o_axi_awvalid, o_axi_wdata, o_axi_wstrb, o_axi_wvalid,
        input  o_axi_bready, o_axi_araddr, o_axi_arvalid, o_axi_rready
    );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI transaction out, one response back.
// Define AXI_LITE_MASTER_TIMEOUT_EN to add a responder timeout that completes with SLVERR.
module axi_lite_master #(
    parameter int ADDR_W_p = 4
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES_p = 16
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    axi_lite_master_if.master   bus,
    output logic [2:0]          o_dbg_state
);
    // Handshakes (all valid/ready pairs): a transfer happens on a rising edge where
    // both valid and ready are high; valid and its payload never change while waiting.
    typedef enum logic [2:0] {
        IDLE, WR_ADDR_DATA, WAIT_B, RD_ADDR, WAIT_R, RESP
    } state_e;

    localparam logic [ADDR_W_p-1:0] WORD_MASK_p = ~ADDR_W_p'(3);

    state_e              state_q, state_d;
    logic [ADDR_W_p-1:0] addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;
    logic [1:0]          rsp_resp_q, rsp_resp_d;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    localparam int CNT_W_p = $clog2(TIMEOUT_CYCLES_p + 1);
    logic [CNT_W_p-1:0] cnt_q, cnt_d;
    logic               busy;
`endif

    // All outputs decode from registered state, so reset clears them immediately.
    assign bus.o_cmd_ready   = (state_q == IDLE);
    assign bus.o_axi_awvalid = (state_q == WR_ADDR_DATA) && !aw_done_q;
    assign bus.o_axi_wvalid  = (state_q == WR_ADDR_DATA) && !w_done_q;
    assign bus.o_axi_bready  = (state_q == WAIT_B);
    assign bus.o_axi_arvalid = (state_q == RD_ADDR);
    assign bus.o_axi_rready  = (state_q == WAIT_R);
    assign bus.o_rsp_valid   = (state_q == RESP);
    assign bus.o_axi_awaddr  = addr_q;
    assign bus.o_axi_araddr  = addr_q;
    assign bus.o_axi_wdata   = wdata_q;
    assign bus.o_axi_wstrb   = wstrb_q;
    assign bus.o_rsp_rdata   = rsp_rdata_q;
    assign bus.o_rsp_resp    = rsp_resp_q;
    assign o_dbg_state       = state_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        unique case (state_q)
            IDLE: begin
                if (bus.i_cmd_valid) begin
                    addr_d    = bus.i_cmd_addr & WORD_MASK_p;
                    wdata_d   = bus.i_cmd_wdata;
                    wstrb_d   = bus.i_cmd_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = bus.i_cmd_write ? WR_ADDR_DATA : RD_ADDR;
                end
            end
            WR_ADDR_DATA: begin
                // AW and W complete independently, in either order or together.
                aw_done_d = aw_done_q | (bus.o_axi_awvalid && bus.i_axi_awready);
                w_done_d  = w_done_q | (bus.o_axi_wvalid && bus.i_axi_wready);
                if (aw_done_d && w_done_d) state_d = WAIT_B;
            end
            WAIT_B: begin
                if (bus.i_axi_bvalid) begin
                    rsp_rdata_d = '0;
                    rsp_resp_d  = bus.i_axi_bresp;
                    state_d     = RESP;
                end
            end
            RD_ADDR: begin
                if (bus.i_axi_arready) state_d = WAIT_R;
            end
            WAIT_R: begin
                if (bus.i_axi_rvalid) begin
                    rsp_rdata_d = bus.i_axi_rdata;
                    rsp_resp_d  = bus.i_axi_rresp;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (bus.i_rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
        busy  = (state_q == WR_ADDR_DATA) || (state_q == WAIT_B) ||
                (state_q == RD_ADDR) || (state_q == WAIT_R);
        cnt_d = cnt_q;
        if (state_q == IDLE && bus.i_cmd_valid) cnt_d = '0;
        else if (busy) cnt_d = cnt_q + CNT_W_p'(1);
        // A real B/R arriving on the expiry cycle still wins over the timeout.
        if (busy && cnt_d == CNT_W_p'(TIMEOUT_CYCLES_p) && state_d != RESP) begin
            state_d     = RESP;
            rsp_rdata_d = '0;
            rsp_resp_d  = 2'b10;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif
endmodule

// File: tb/tb_axi_lite_master.sv
// Randomized bench for axi_lite_master: AXI responder with a scratchpad, reference memory model,
// response scoreboard and a per-cycle protocol monitor, plus directed corner cases.
`timescale 1ns/1ps
module tb_axi_lite_master;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_lite_master_if #(.ADDR_W_p(AW)) bus();
    logic [2:0] dbg_state;

    axi_lite_master #(.ADDR_W_p(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // Responder / stimulus knobs
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0, stall_dly = 0;
    bit spur_en = 1'b0;
    bit to_mode = 1'b0;

    logic [31:0] slv_mem [4];
    logic [31:0] mdl_mem [4];

    logic [1:0]    plan_q[$];
    logic [33:0]   exp_q[$];
    logic [AW-1:0] exp_aw_q[$];
    logic [AW-1:0] exp_ar_q[$];
    logic [35:0]   exp_w_q[$];

    // Measured by the monitor
    int last_lat = 0, aw_len = 0, w_len = 0, b_len = 0, ar_len = 0, rv_len = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic void flag_err(string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event missing or unexpected (t=%0t)", nm, $time);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- AXI responder + response consumer ----------------
    initial begin : responder
        int aw_w, w_w, b_w, ar_w, r_w, st_w;
        bit aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_got, w_got, pend_b, pend_r;
        logic [AW-1:0] wa, ra;
        logic [31:0]   wd;
        logic [3:0]    ws;
        logic [1:0]    cur;
        {aw_w, w_w, b_w, ar_w, r_w, st_w} = '0;
        {aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_got, w_got, pend_b, pend_r} = '0;
        wa = '0; ra = '0; wd = '0; ws = '0; cur = '0;
        {bus.i_axi_awready, bus.i_axi_wready, bus.i_axi_bvalid, bus.i_axi_arready} = '0;
        {bus.i_axi_rvalid, bus.i_rsp_ready} = '0;
        bus.i_axi_bresp = '0; bus.i_axi_rresp = '0; bus.i_axi_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                {aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_got, w_got, pend_b, pend_r} = '0;
                {bus.i_axi_awready, bus.i_axi_wready, bus.i_axi_bvalid, bus.i_axi_arready} = '0;
                {bus.i_axi_rvalid, bus.i_rsp_ready} = '0;
                continue;
            end
            // Results of the handshakes sampled at the edge just passed
            if (aw_hs) aw_got = 1'b1;
            if (w_hs) w_got = 1'b1;
            if (aw_got && w_got) begin
                for (int b = 0; b < 4; b++)
                    if (ws[b]) slv_mem[wa[3:2]][8*b +: 8] = wd[8*b +: 8];
                cur = (plan_q.size() != 0) ? plan_q.pop_front() : 2'b11;
                pend_b = 1'b1; b_w = b_dly; aw_got = 1'b0; w_got = 1'b0;
            end
            if (b_hs) pend_b = 1'b0;
            if (ar_hs) begin
                cur = (plan_q.size() != 0) ? plan_q.pop_front() : 2'b11;
                pend_r = 1'b1; r_w = r_dly;
            end
            if (r_hs) pend_r = 1'b0;

            if (bus.o_axi_awvalid) begin
                if (aw_w > 0) begin aw_w--; bus.i_axi_awready = 1'b0; end
                else bus.i_axi_awready = 1'b1;
            end else begin aw_w = aw_dly; bus.i_axi_awready = 1'b0; end
            if (bus.o_axi_wvalid) begin
                if (w_w > 0) begin w_w--; bus.i_axi_wready = 1'b0; end
                else bus.i_axi_wready = 1'b1;
            end else begin w_w = w_dly; bus.i_axi_wready = 1'b0; end
            if (bus.o_axi_arvalid) begin
                if (ar_w > 0) begin ar_w--; bus.i_axi_arready = 1'b0; end
                else bus.i_axi_arready = 1'b1;
            end else begin ar_w = ar_dly; bus.i_axi_arready = 1'b0; end

            if (pend_b) begin
                if (b_w > 0) begin b_w--; bus.i_axi_bvalid = 1'b0; end
                else begin bus.i_axi_bvalid = 1'b1; bus.i_axi_bresp = cur; end
            end else if (spur_en && !bus.o_axi_bready && $urandom_range(0, 3) == 0) begin
                bus.i_axi_bvalid = 1'b1; bus.i_axi_bresp = 2'($urandom);
            end else bus.i_axi_bvalid = 1'b0;

            if (pend_r) begin
                if (r_w > 0) begin r_w--; bus.i_axi_rvalid = 1'b0; end
                else begin
                    bus.i_axi_rvalid = 1'b1; bus.i_axi_rresp = cur;
                    bus.i_axi_rdata = slv_mem[ra[3:2]];
                end
            end else if (spur_en && !bus.o_axi_rready && $urandom_range(0, 3) == 0) begin
                bus.i_axi_rvalid = 1'b1; bus.i_axi_rresp = 2'($urandom);
                bus.i_axi_rdata = $urandom;
            end else bus.i_axi_rvalid = 1'b0;

            if (bus.o_rsp_valid) begin
                if (st_w > 0) begin st_w--; bus.i_rsp_ready = 1'b0; end
                else bus.i_rsp_ready = 1'b1;
            end else begin st_w = stall_dly; bus.i_rsp_ready = 1'($urandom_range(0, 1)); end

            aw_hs = bus.o_axi_awvalid && bus.i_axi_awready;
            if (aw_hs) wa = bus.o_axi_awaddr;
            w_hs = bus.o_axi_wvalid && bus.i_axi_wready;
            if (w_hs) begin wd = bus.o_axi_wdata; ws = bus.o_axi_wstrb; end
            b_hs = bus.i_axi_bvalid && bus.o_axi_bready;
            ar_hs = bus.o_axi_arvalid && bus.i_axi_arready;
            if (ar_hs) ra = bus.o_axi_araddr;
            r_hs = bus.i_axi_rvalid && bus.o_axi_rready;
        end
    end

    // ---------------- Monitor: protocol checks + scoreboard ----------------
    initial begin : monitor
        bit busy, aw_seen, w_seen, ar_seen;
        bit p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rv, p_rr;
        logic [AW-1:0] p_awaddr, p_araddr;
        logic [35:0]   p_w;
        logic [33:0]   p_rsp;
        int aw_run, w_run, b_run, ar_run, rv_run, acc_cyc;
        logic [33:0] e;
        {busy, aw_seen, w_seen, ar_seen} = '0;
        {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rv, p_rr} = '0;
        p_awaddr = '0; p_araddr = '0; p_w = '0; p_rsp = '0;
        {aw_run, w_run, b_run, ar_run, rv_run, acc_cyc} = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                {busy, aw_seen, w_seen, ar_seen} = '0;
                {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rv, p_rr} = '0;
                {aw_run, w_run, b_run, ar_run, rv_run} = '0;
                continue;
            end
            chk("cmd_ready_idle_only", bus.o_cmd_ready, !busy);
            if (p_awv && !p_awr && !to_mode)
                chk("aw_hold", {bus.o_axi_awvalid, bus.o_axi_awaddr}, {1'b1, p_awaddr});
            if (p_awv && p_awr) chk("aw_drop", bus.o_axi_awvalid, 1'b0);
            if (p_wv && !p_wr && !to_mode)
                chk("w_hold", {bus.o_axi_wvalid, bus.o_axi_wdata, bus.o_axi_wstrb}, {1'b1, p_w});
            if (p_wv && p_wr) chk("w_drop", bus.o_axi_wvalid, 1'b0);
            if (p_arv && !p_arr && !to_mode)
                chk("ar_hold", {bus.o_axi_arvalid, bus.o_axi_araddr}, {1'b1, p_araddr});
            if (p_arv && p_arr) chk("ar_drop", bus.o_axi_arvalid, 1'b0);
            if (p_rv && !p_rr)
                chk("rsp_hold", {bus.o_rsp_valid, bus.o_rsp_rdata, bus.o_rsp_resp}, {1'b1, p_rsp});
            if (bus.o_axi_bready) chk("bready_after_aw_w", {aw_seen, w_seen}, 2'b11);
            if (bus.o_axi_rready) chk("rready_after_ar", ar_seen, 1'b1);

            if (bus.o_axi_awvalid && bus.i_axi_awready) begin
                aw_seen = 1'b1;
                if (exp_aw_q.size() != 0) chk("awaddr", bus.o_axi_awaddr, exp_aw_q.pop_front());
                else flag_err("aw_unexpected");
            end
            if (bus.o_axi_wvalid && bus.i_axi_wready) begin
                w_seen = 1'b1;
                if (exp_w_q.size() != 0)
                    chk("wdata_wstrb", {bus.o_axi_wdata, bus.o_axi_wstrb}, exp_w_q.pop_front());
                else flag_err("w_unexpected");
            end
            if (bus.o_axi_arvalid && bus.i_axi_arready) begin
                ar_seen = 1'b1;
                if (exp_ar_q.size() != 0) chk("araddr", bus.o_axi_araddr, exp_ar_q.pop_front());
                else flag_err("ar_unexpected");
            end
            if (bus.o_rsp_valid && bus.i_rsp_ready) begin
                last_lat = cyc - acc_cyc + 1;
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata_resp", {bus.o_rsp_rdata, bus.o_rsp_resp}, e);
                end else flag_err("rsp_unexpected");
                busy = 1'b0;
            end
            if (bus.i_cmd_valid && bus.o_cmd_ready) begin
                busy = 1'b1; acc_cyc = cyc;
                {aw_seen, w_seen, ar_seen} = '0;
            end

            if (bus.o_axi_awvalid) aw_run++; else begin if (aw_run > 0) aw_len = aw_run; aw_run = 0; end
            if (bus.o_axi_wvalid) w_run++; else begin if (w_run > 0) w_len = w_run; w_run = 0; end
            if (bus.o_axi_bready) b_run++; else begin if (b_run > 0) b_len = b_run; b_run = 0; end
            if (bus.o_axi_arvalid) ar_run++; else begin if (ar_run > 0) ar_len = ar_run; ar_run = 0; end
            if (bus.o_rsp_valid) rv_run++; else begin if (rv_run > 0) rv_len = rv_run; rv_run = 0; end

            p_awv = bus.o_axi_awvalid; p_awr = bus.i_axi_awready; p_awaddr = bus.o_axi_awaddr;
            p_wv = bus.o_axi_wvalid; p_wr = bus.i_axi_wready; p_w = {bus.o_axi_wdata, bus.o_axi_wstrb};
            p_arv = bus.o_axi_arvalid; p_arr = bus.i_axi_arready; p_araddr = bus.o_axi_araddr;
            p_rv = bus.o_rsp_valid; p_rr = bus.i_rsp_ready;
            p_rsp = {bus.o_rsp_rdata, bus.o_rsp_resp};
        end
    end

    // ---------------- Driver tasks ----------------
    task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [1:0] resp, input bit expect_to);
        bit done = 1'b0;
        @(negedge clk);
        bus.i_cmd_valid = 1'b1; bus.i_cmd_write = wr; bus.i_cmd_addr = a;
        bus.i_cmd_wdata = d; bus.i_cmd_wstrb = s;
        for (int t = 0; t < 200 && !done; t++) begin
            #2;
            if (bus.o_cmd_ready) begin
                done = 1'b1;
                if (expect_to) begin
                    exp_q.push_back({32'h0, 2'b10});
                end else if (wr) begin
                    plan_q.push_back(resp);
                    for (int b = 0; b < 4; b++)
                        if (s[b]) mdl_mem[a[3:2]][8*b +: 8] = d[8*b +: 8];
                    exp_aw_q.push_back({a[AW-1:2], 2'b00});
                    exp_w_q.push_back({d, s});
                    exp_q.push_back({32'h0, resp});
                end else begin
                    plan_q.push_back(resp);
                    exp_ar_q.push_back({a[AW-1:2], 2'b00});
                    exp_q.push_back({mdl_mem[a[3:2]], resp});
                end
            end
            @(negedge clk);
        end
        bus.i_cmd_valid = 1'b0;
        if (!done) flag_err("cmd_accept_timeout");
    endtask

    task automatic wait_done();
        bit done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            #3;
            if (exp_q.size() == 0 && bus.o_cmd_ready) done = 1'b1;
        end
        if (!done) flag_err("response_timeout");
    endtask

    task automatic set_dly(input int a, input int w, input int b, input int ar, input int r, input int st);
        aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r; stall_dly = st;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not complete");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // ---------------- Main sequence ----------------
    initial begin
        bus.i_cmd_valid = 1'b0; bus.i_cmd_write = 1'b0; bus.i_cmd_addr = '0;
        bus.i_cmd_wdata = '0; bus.i_cmd_wstrb = '0;
        for (int i = 0; i < 4; i++) begin
            slv_mem[i] = $urandom;
            mdl_mem[i] = slv_mem[i];
        end

        repeat (3) @(negedge clk);
        #1;
        chk("reset_valids", {bus.o_axi_awvalid, bus.o_axi_wvalid, bus.o_axi_bready,
            bus.o_axi_arvalid, bus.o_axi_rready, bus.o_rsp_valid}, 6'b0);
        chk("reset_rsp_regs", {bus.o_rsp_rdata, bus.o_rsp_resp}, 34'h0);
        chk("reset_addr_data", {bus.o_axi_awaddr, bus.o_axi_wdata, bus.o_axi_wstrb}, 40'h0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1 chk("cmd_ready_after_reset", bus.o_cmd_ready, 1'b1);

        // Zero-wait write
        set_dly(0, 0, 0, 0, 0, 0);
        issue(1'b1, 4'h4, 32'hDEADBEEF, 4'hF, 2'b00, 1'b0);
        wait_done();
        chk("zero_wait_latency", last_lat, 4);
        chk("zw_awvalid_len", aw_len, 1);
        chk("zw_wvalid_len", w_len, 1);
        chk("zw_bready_len", b_len, 1);

        // Read of an unaligned address
        slv_mem[1] = 32'hCAFEF00D;
        mdl_mem[1] = 32'hCAFEF00D;
        issue(1'b0, 4'h6, 32'h0, 4'h0, 2'b00, 1'b0);
        wait_done();

        // AW accepted late, W immediately
        set_dly(3, 0, 0, 0, 0, 0);
        issue(1'b1, 4'h8, 32'h12345678, 4'h5, 2'b00, 1'b0);
        wait_done();
        chk("late_aw_awvalid_len", aw_len, 4);
        chk("late_aw_wvalid_len", w_len, 1);

        // Consumer stalls the response
        set_dly(0, 0, 0, 0, 0, 5);
        issue(1'b0, 4'h8, 32'h0, 4'h0, 2'b01, 1'b0);
        wait_done();
        chk("stall_rsp_valid_len", rv_len, 6);

        // Randomized traffic with responder and consumer back-pressure
        spur_en = 1'b1;
        for (int n = 0; n < 60; n++) begin
            set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            issue(1'($urandom), 4'($urandom), $urandom, 4'($urandom), 2'($urandom), 1'b0);
        end
        wait_done();
        spur_en = 1'b0;

        // Asynchronous reset while waiting for read data
        set_dly(0, 0, 0, 0, 50, 0);
        issue(1'b0, 4'hC, 32'h0, 4'h0, 2'b00, 1'b0);
        begin
            bit seen = 1'b0;
            for (int t = 0; t < 100 && !seen; t++) begin
                @(negedge clk);
                #1 seen = bus.o_axi_rready;
            end
            if (!seen) flag_err("reach_wait_r");
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valids", {bus.o_axi_awvalid, bus.o_axi_wvalid, bus.o_axi_bready,
            bus.o_axi_arvalid, bus.o_axi_rready, bus.o_rsp_valid}, 6'b0);
        chk("async_rst_rsp_regs", {bus.o_rsp_rdata, bus.o_rsp_resp}, 34'h0);
        exp_q.delete(); plan_q.delete(); exp_ar_q.delete(); exp_aw_q.delete(); exp_w_q.delete();
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1 chk("cmd_ready_after_async_rst", bus.o_cmd_ready, 1'b1);
        set_dly(0, 0, 0, 0, 0, 0);
        issue(1'b0, 4'h4, 32'h0, 4'h0, 2'b00, 1'b0);
        wait_done();

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
        // Read address never accepted
        to_mode = 1'b1;
        set_dly(0, 0, 0, 100000, 0, 0);
        issue(1'b0, 4'h0, 32'h0, 4'h0, 2'b00, 1'b1);
        wait_done();
        chk("timeout_arvalid_len", ar_len, 16);
        to_mode = 1'b0;
        set_dly(0, 0, 0, 0, 0, 0);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
